// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side fields, forwarding sources and ALU-facing outputs for the
// ID/EX stage. The stage is the slave; whatever drives ID and consumes EX is the master.
interface id_ex_stage_if #(
    parameter int bit_size = 32
);
    // ID-stage instruction fields and register-file reads
    logic                id_valid;
    logic [5:0]          id_opcode;
    logic [5:0]          id_funct;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic [4:0]          id_rd;
    logic [4:0]          id_shamt;
    logic [15:0]         id_imm;
    logic [bit_size-1:0] id_rs_data;
    logic [bit_size-1:0] id_rt_data;

    logic                hold;
    logic                flush;

    // forwarding sources from later stages
    logic                exm_reg_write;
    logic [4:0]          exm_rd;
    logic [bit_size-1:0] exm_result;
    logic                mwb_reg_write;
    logic [4:0]          mwb_rd;
    logic [bit_size-1:0] mwb_data;

    // EX-stage outputs
    logic [3:0]          ALUOp;
    logic [bit_size-1:0] src1;
    logic [bit_size-1:0] src2;
    logic [4:0]          shamt;
    logic                ex_valid;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_branch;
    logic [4:0]          ex_rd;
    logic [bit_size-1:0] ex_store_data;
    logic                load_use_stall;

    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
        output id_rs_data, id_rt_data, hold, flush,
        output exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_data,
        input  ALUOp, src1, src2, shamt, ex_valid, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_branch, ex_rd, ex_store_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
        input  id_rs_data, id_rt_data, hold, flush,
        input  exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_data,
        output ALUOp, src1, src2, shamt, ex_valid, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_branch, ex_rd, ex_store_data, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes at capture, forwards EX/MEM and MEM/WB results
// into the ALU operands, and inserts a single bubble on a load-use hazard.
module id_ex_stage #(
    parameter int bit_size = 32
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;

    typedef struct packed {
        logic                valid;
        logic [3:0]          aluop;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                use_imm;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [4:0]          shamt;
        logic [bit_size-1:0] rs_data;
        logic [bit_size-1:0] rt_data;
        logic [bit_size-1:0] imm;
    } stage_t;

    stage_t stage_reg;
    stage_t stage_next;
    stage_t dec;

    logic                dec_ok;
    logic                dec_reads_rt;
    logic [bit_size-1:0] sign_imm;
    logic [bit_size-1:0] zero_imm;
    logic                load_use_hit;
    logic                load_use_stall;

    assign sign_imm = {{(bit_size-16){bus.id_imm[15]}}, bus.id_imm};
    assign zero_imm = {{(bit_size-16){1'b0}}, bus.id_imm};

    // Decode the ID fields into the shape the stage register holds
    always_comb begin
        dec          = '0;
        dec_reads_rt = 1'b0;
        dec.rs       = bus.id_rs;
        dec.rt       = bus.id_rt;
        dec.rs_data  = bus.id_rs_data;
        dec.rt_data  = bus.id_rt_data;
        case (bus.id_opcode)
            OP_RTYPE: begin
                dec_reads_rt  = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = bus.id_rd;
                case (bus.id_funct)
                    FN_ADD:  dec.aluop = ALU_ADD;
                    FN_SUB:  dec.aluop = ALU_SUB;
                    FN_AND:  dec.aluop = ALU_AND;
                    FN_OR:   dec.aluop = ALU_OR;
                    FN_XOR:  dec.aluop = ALU_XOR;
                    FN_NOR:  dec.aluop = ALU_NOR;
                    FN_SLT:  dec.aluop = ALU_SLT;
                    FN_SLL:  begin dec.aluop = ALU_SLL; dec.shamt = bus.id_shamt; end
                    FN_SRL:  begin dec.aluop = ALU_SRL; dec.shamt = bus.id_shamt; end
                    default: dec.aluop = ALU_NONE;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_LW: begin
                dec.aluop     = (bus.id_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.imm       = sign_imm;
                dec.reg_write = 1'b1;
                dec.mem_read  = (bus.id_opcode == OP_LW);
                dec.rd        = bus.id_rt;
            end
            OP_ANDI, OP_ORI: begin
                dec.aluop     = (bus.id_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                dec.use_imm   = 1'b1;
                dec.imm       = zero_imm;
                dec.reg_write = 1'b1;
                dec.rd        = bus.id_rt;
            end
            OP_SW: begin
                dec_reads_rt  = 1'b1;
                dec.aluop     = ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.imm       = sign_imm;
                dec.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_reads_rt  = 1'b1;
                dec.aluop     = (bus.id_opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                dec.branch    = 1'b1;
            end
            default: dec.aluop = ALU_NONE;
        endcase
        dec_ok    = (dec.aluop != ALU_NONE);
        dec.valid = dec_ok;
    end

    // A load in EX whose destination the ID instruction reads needs one bubble
    assign load_use_hit = stage_reg.valid && stage_reg.mem_read && (stage_reg.rd != 5'd0)
                          && bus.id_valid
                          && ((bus.id_rs == stage_reg.rd)
                              || ((bus.id_rt == stage_reg.rd) && dec_reads_rt));
    assign load_use_stall = load_use_hit && !bus.flush && !bus.hold;

    always_comb begin
        stage_next = stage_reg;
        if (bus.flush) begin
            stage_next = '0;
        end else if (bus.hold) begin
            stage_next = stage_reg;
        end else if (load_use_stall || !bus.id_valid || !dec_ok) begin
            stage_next = '0;
        end else begin
            stage_next = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    // Operand 0 is rs, operand 1 is rt; EX/MEM beats MEM/WB, $0 never forwards
    logic [4:0]          op_reg    [2];
    logic [bit_size-1:0] op_latched[2];
    logic [bit_size-1:0] op_fwd    [2];

    assign op_reg[0]     = stage_reg.rs;
    assign op_reg[1]     = stage_reg.rt;
    assign op_latched[0] = stage_reg.rs_data;
    assign op_latched[1] = stage_reg.rt_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic exm_hit;
            logic mwb_hit;
            assign exm_hit = bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == op_reg[gi]);
            assign mwb_hit = bus.mwb_reg_write && (bus.mwb_rd != 5'd0) && (bus.mwb_rd == op_reg[gi]);
            assign op_fwd[gi] = exm_hit ? bus.exm_result :
                                mwb_hit ? bus.mwb_data   : op_latched[gi];
        end
    endgenerate

    assign bus.src1           = op_fwd[0];
    assign bus.src2           = stage_reg.use_imm ? stage_reg.imm : op_fwd[1];
    assign bus.ex_store_data  = op_fwd[1];
    assign bus.shamt          = stage_reg.shamt;
    assign bus.ALUOp          = stage_reg.aluop;
    assign bus.ex_valid       = stage_reg.valid;
    assign bus.ex_reg_write   = stage_reg.reg_write;
    assign bus.ex_mem_read    = stage_reg.mem_read;
    assign bus.ex_mem_write   = stage_reg.mem_write;
    assign bus.ex_branch      = stage_reg.branch;
    assign bus.ex_rd          = stage_reg.rd;
    assign bus.load_use_stall = load_use_stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, load-use bubble,
// hold/flush and reset behaviour against hand-computed values.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.bit_size(32)) bus ();

    id_ex_stage #(.bit_size(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                          input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
        bus.id_valid   = 1'b1;
        bus.id_opcode  = op;
        bus.id_funct   = fn;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_shamt   = sh;
        bus.id_imm     = imm;
        bus.id_rs_data = rsd;
        bus.id_rt_data = rtd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.hold          = 1'b0;
        bus.flush         = 1'b0;
        bus.exm_reg_write = 1'b0;
        bus.exm_rd        = 5'd0;
        bus.exm_result    = 32'd0;
        bus.mwb_reg_write = 1'b0;
        bus.mwb_rd        = 5'd0;
        bus.mwb_data      = 32'd0;
        set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);

        // reset held for two edges with a valid add in ID
        tick();
        tick();
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_aluop", 32'(bus.ALUOp), 32'd0);
        check("rst_src1", bus.src1, 32'd0);
        check("rst_src2", bus.src2, 32'd0);
        check("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
        check("rst_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check("rst_store", bus.ex_store_data, 32'd0);
        check("rst_stall", 32'(bus.load_use_stall), 32'd0);
        rst = 1'b1;

        // add $3,$1,$2
        tick();
        check("add_aluop", 32'(bus.ALUOp), 32'd1);
        check("add_src1", bus.src1, 32'd5);
        check("add_src2", bus.src2, 32'd7);
        check("add_ex_rd", 32'(bus.ex_rd), 32'd3);
        check("add_reg_write", 32'(bus.ex_reg_write), 32'd1);
        check("add_ex_valid", 32'(bus.ex_valid), 32'd1);

        // andi $4,$1,0xFFFF
        set_id(6'h0C, 6'h00, 5'd1, 5'd4, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'd9);
        tick();
        check("andi_aluop", 32'(bus.ALUOp), 32'd3);
        check("andi_src2", bus.src2, 32'h0000FFFF);
        check("andi_ex_rd", 32'(bus.ex_rd), 32'd4);

        // addi $4,$1,-1
        set_id(6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'd9);
        tick();
        check("addi_aluop", 32'(bus.ALUOp), 32'd1);
        check("addi_src2", bus.src2, 32'hFFFFFFFF);

        // forwarding priority on rs=2
        set_id(6'h00, 6'h20, 5'd2, 5'd3, 5'd4, 5'd0, 16'h0000, 32'h11, 32'h22);
        tick();
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd2; bus.exm_result = 32'hAA;
        bus.mwb_reg_write = 1'b1; bus.mwb_rd = 5'd2; bus.mwb_data   = 32'hBB;
        #1;
        check("fwd_exm_prio", bus.src1, 32'hAA);
        bus.exm_reg_write = 1'b0;
        #1;
        check("fwd_mwb", bus.src1, 32'hBB);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd0; bus.mwb_rd = 5'd0;
        #1;
        check("fwd_r0_latched", bus.src1, 32'h11);
        bus.mwb_rd = 5'd3;
        #1;
        check("fwd_rt_src2", bus.src2, 32'hBB);
        bus.exm_reg_write = 1'b0; bus.mwb_reg_write = 1'b0; bus.mwb_rd = 5'd0;

        // load-use: lw $5 in EX, add $6,$5,$1 in ID
        set_id(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0000, 32'd5, 32'd0);
        tick();
        check("lw_mem_read", 32'(bus.ex_mem_read), 32'd1);
        check("lw_ex_rd", 32'(bus.ex_rd), 32'd5);
        set_id(6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 5'd0, 16'h0000, 32'd0, 32'd5);
        #1;
        check("lu_add_stall", 32'(bus.load_use_stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bubble_stall", 32'(bus.load_use_stall), 32'd0);
        tick();
        check("lu_recap_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_recap_rd", 32'(bus.ex_rd), 32'd6);

        // load-use: sw reads rt, addi does not
        set_id(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0000, 32'd5, 32'd0);
        tick();
        set_id(6'h2B, 6'h00, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0000, 32'd5, 32'd0);
        #1;
        check("lu_sw_stall", 32'(bus.load_use_stall), 32'd1);
        bus.hold = 1'b1;
        #1;
        check("lu_hold_mask", 32'(bus.load_use_stall), 32'd0);
        bus.hold = 1'b0;
        set_id(6'h08, 6'h00, 5'd1, 5'd7, 5'd0, 5'd0, 16'h0004, 32'd5, 32'd0);
        #1;
        check("lu_addi7_nostall", 32'(bus.load_use_stall), 32'd0);
        set_id(6'h08, 6'h00, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0004, 32'd5, 32'd0);
        #1;
        check("lu_addi5_nostall", 32'(bus.load_use_stall), 32'd0);

        // hold for 3 cycles keeps add $3
        set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);
        tick();
        bus.hold = 1'b1;
        set_id(6'h0C, 6'h00, 5'd1, 5'd4, 5'd0, 5'd0, 16'h1234, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_aluop", i), 32'(bus.ALUOp), 32'd1);
            check($sformatf("hold%0d_src2", i), bus.src2, 32'd7);
            check($sformatf("hold%0d_rd", i), 32'(bus.ex_rd), 32'd3);
        end
        bus.flush = 1'b1;
        tick();
        check("flush_hold_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_hold_aluop", 32'(bus.ALUOp), 32'd0);
        bus.flush = 1'b0;
        bus.hold  = 1'b0;

        // beq $1,$2 with equal operands
        set_id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0010, 32'd9, 32'd9);
        tick();
        check("beq_aluop", 32'(bus.ALUOp), 32'd10);
        check("beq_branch", 32'(bus.ex_branch), 32'd1);
        check("beq_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check("beq_src2", bus.src2, 32'd9);

        // sll $3,$2,4
        set_id(6'h00, 6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 16'h0000, 32'd0, 32'h55);
        tick();
        check("sll_aluop", 32'(bus.ALUOp), 32'd8);
        check("sll_shamt", 32'(bus.shamt), 32'd4);
        check("sll_src2", bus.src2, 32'h55);

        // unknown opcode and unknown funct
        set_id(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);
        tick();
        check("unk_op_valid", 32'(bus.ex_valid), 32'd0);
        check("unk_op_aluop", 32'(bus.ALUOp), 32'd0);
        set_id(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);
        tick();
        check("unk_fn_valid", 32'(bus.ex_valid), 32'd0);

        // id_valid low gives a bubble
        set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);
        bus.id_valid = 1'b0;
        tick();
        check("novalid_valid", 32'(bus.ex_valid), 32'd0);

        // reset during hold clears the stage
        bus.id_valid = 1'b1;
        tick();
        check("prehold_valid", 32'(bus.ex_valid), 32'd1);
        bus.hold = 1'b1;
        rst = 1'b0;
        tick();
        check("rst_in_hold_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_in_hold_rd", 32'(bus.ex_rd), 32'd0);
        rst = 1'b1;
        bus.hold = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage that directly feeds the EX-stage ALU. It latches decoded instruction fields and register-file reads from ID and generates the 4-bit ALUOp. It applies EX/MEM and MEM/WB forwarding to produce `src1`, `src2` and `shamt`, and detects load-use hazards, inserting a bubble when one occurs. It also supports hold (pipeline freeze) and flush (taken-branch squash).

## Interface
- `bit_size`, 32, datapath width
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous reset, active-low
- `id_valid` in 1, ID holds a real instruction
- `id_opcode` in 6; `id_funct` in 6; `id_rs` `id_rt` `id_rd` `id_shamt` in 5 each; `id_imm` in 16, decoded fields
- `id_rs_data` `id_rt_data` in bit_size, register-file reads
- `hold` in 1, freeze stage contents (memory stall)
- `flush` in 1, squash incoming instruction (taken branch)
- `exm_reg_write` in 1; `exm_rd` in 5; `exm_result` in bit_size, EX/MEM forwarding source
- `mwb_reg_write` in 1; `mwb_rd` in 5; `mwb_data` in bit_size, MEM/WB forwarding source
- `ALUOp` out 4; `src1` `src2` out bit_size; `shamt` out 5, to ALU
- `ex_valid` `ex_reg_write` `ex_mem_read` `ex_mem_write` `ex_branch` out 1 each
- `ex_rd` out 5, destination register
- `ex_store_data` out bit_size, forwarded rt value for sw
- `load_use_stall` out 1, to PC/IF/ID: hold upstream this cycle

## Operation
- Decode at capture. R-type (opcode 0) maps funct to ALUOp: 0x20→1 add, 0x22→2 sub, 0x24→3 and, 0x25→4 or, 0x26→5 xor, 0x27→6 nor, 0x2A→7 slt, 0x00→8 sll, 0x02→9 srl. Destination is rd; reg_write=1.
- I-type ALU ops:
  - addi 0x08→1, sign-extended imm.
  - slti 0x0A→7, sign-extended imm.
  - andi 0x0C→3, zero-extended imm.
  - ori 0x0D→4, zero-extended imm.
  - Destination is rt; reg_write=1.
- lw 0x23: ALUOp 1, sign-extended imm, mem_read=1, reg_write=1, destination rt.
- sw 0x2B: ALUOp 1, sign-extended imm, mem_write=1, reg_write=0.
- beq 0x04→10, bne 0x05→11: branch=1, reg_write=0, src2 taken from rt.
- Any unlisted opcode or funct decodes to a bubble.
- Bubble means all control outputs 0, ALUOp 0, `ex_rd` 0, stored data/imm/shamt 0, `ex_valid` 0.
- Register update each cycle, in priority order:
  1. `!rst` → bubble.
  2. `flush` → bubble.
  3. `hold` → keep contents.
  4. `load_use_stall` → bubble.
  5. `id_valid` → capture.
  6. Otherwise → bubble.
- Forwarding is combinational on the registered rs/rt, applied separately for each operand:
  - EX/MEM source matches when `exm_reg_write && exm_rd!=0 && exm_rd==reg`.
  - Otherwise MEM/WB source matches under the same rule using `mwb_*`.
  - Otherwise the latched register-file value is used.
  - EX/MEM has priority when both match.
- Operand selection:
  - `src1` = forwarded rs.
  - `src2` = extended imm for I-type ALU ops, lw and sw; forwarded rt for R-type and branches.
  - `ex_store_data` = forwarded rt always.
  - `shamt` = latched shamt for sll/srl, 0 otherwise.
- Load-use detection: `load_use_stall` = `ex_valid && ex_mem_read && ex_rd!=0 && id_valid && (id_rs==ex_rd || (id_rt==ex_rd && ID reads rt))`.
  - ID reads rt for R-type, sw, beq and bne.
  - `load_use_stall` is forced to 0 when `flush` or `hold` is asserted.
- Register 0 is never forwarded and never causes a stall.

## Timing
- Capture latency: fields presented at edge N appear on registered outputs after edge N.
- `src1`/`src2` forwarding is combinational, so it tracks `exm_*`/`mwb_*` within the same cycle.
- Reset: after the first edge with `rst`=0, every registered output is 0. `ALUOp`, `src1`, `src2`, `shamt`, `ex_store_data` and `load_use_stall` are then 0, provided no forwarding source matches.
- Load-use: exactly one bubble is inserted. The instruction is recaptured on the following edge, since upstream holds ID.
- `hold` and `flush` in the same cycle: flush wins.
- Reset asserted mid-stall or mid-hold clears the stage on that edge.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `id_valid`=1 (add) → all outputs 0, `ex_valid`=0.
- Decode: capture `add $3,$1,$2` with rs_data 5, rt_data 7, no forwarding matches → ALUOp 1, src1 5, src2 7, `ex_rd` 3, `ex_reg_write` 1. Then `andi $4,$1,0xFFFF` → ALUOp 3, src2 0x0000FFFF. Then `addi` with imm 0xFFFF → src2 0xFFFFFFFF.
- Forwarding priority: registered rs=2; `exm_rd`=2/`exm_result`=0xAA; `mwb_rd`=2/`mwb_data`=0xBB → src1 0xAA. Drop `exm_reg_write` → src1 0xBB. Set both rd=0 → latched value.
- Load-use: `lw $5` in stage, ID holds `add $6,$5,$1` → `load_use_stall`=1, next cycle is a bubble (`ex_valid` 0), following cycle captures the add. Same case with ID `sw $5,0($1)` → stall. With ID `addi $7,$1,4` → no stall.
- Hold/flush: `hold` for 3 cycles → outputs stable. `flush` together with `hold` → bubble. `beq` with equal operands → ALUOp 10, `ex_branch` 1, `ex_reg_write` 0.
- Unknown opcode 0x3F with `id_valid`=1 → bubble captured, `ex_valid` 0.
